// File: rtl/bus_initiator.sv
// Simple-bus initiator: one client request -> one a/d/web/rd transaction; accept->resp_valid >= 3 cycles.
// Backpressure: req_ready is high only in IDLE, so exactly one transaction is in flight at a time.
module bus_initiator #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic [3:0]  web,
  output logic        rd,
  input  logic [31:0] spo,
  input  logic        ready
);

  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
  localparam bit            TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d, d_q, d_d;
  logic [3:0]    wstrb_q, wstrb_d, web_q, web_d;
  logic          rd_q, rd_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          is_read;

  assign is_read = (wstrb_q == 4'b0000);
  // Saturating increment so a disabled timeout (TIMEOUT=0) never wraps.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    d_d          = d_q;
    wstrb_d      = wstrb_q;
    web_d        = web_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_REQ;
          a_d     = req_addr;
          d_d     = req_wdata;
          wstrb_d = req_wstrb;
          web_d   = req_wstrb;
          rd_d    = (req_wstrb == 4'b0000);
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        web_d   = 4'b0000;
        rd_d    = 1'b0;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A device finishing on the timeout cycle still counts as a normal completion.
        if (ready) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = is_read ? spo : 32'h0;
        end else if (TO_EN && (cnt_inc == TO_C)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = is_read ? ERR_DATA : 32'h0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 32'h0;
      d_q          <= 32'h0;
      wstrb_q      <= 4'b0000;
      web_q        <= 4'b0000;
      rd_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      d_q          <= d_d;
      wstrb_q      <= wstrb_d;
      web_q        <= web_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign a          = a_q;
  assign d          = d_q;
  assign web        = web_q;
  assign rd         = rd_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator (TIMEOUT=8): directed scenarios plus random transactions vs. a latency/data model.
module tb_bus_initiator;

  localparam int          TO       = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] a;
  logic [31:0] d;
  logic [3:0]  web;
  logic        rd;
  logic [31:0] spo = 32'h0;
  logic        ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  bus_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .a(a), .d(d), .web(web), .rd(rd), .spo(spo), .ready(ready)
  );

  always #5 clk = ~clk;

  // One transaction; the device raises ready in WAIT cycle number nwait (0 = first WAIT cycle).
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int nwait, input logic [31:0] dev_data,
                         input bit tied);
    bit          is_rd, exp_err, got;
    int          exp_lat, cyc, rd_cnt, rd_cyc, web_cnt, hold_bad, both_bad, rdy_bad;
    logic [31:0] exp_data;
    logic [3:0]  web_seen;
    is_rd = (wstrb == 4'h0);
    if (TO != 0 && nwait >= TO) begin
      exp_err = 1'b1; exp_lat = 2 + TO; exp_data = is_rd ? ERR_WORD : 32'h0;
    end else begin
      exp_err = 1'b0; exp_lat = 3 + nwait; exp_data = is_rd ? dev_data : 32'h0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    ready = tied; spo = tied ? dev_data : $urandom;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s accept: req_ready=%b expected 1", tag, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    cyc = 1; got = 1'b0; rd_cnt = 0; rd_cyc = -1; web_cnt = 0; web_seen = 4'h0;
    hold_bad = 0; both_bad = 0; rdy_bad = 0;
    while (!got && cyc <= 64) begin
      if (rd === 1'b1) begin rd_cnt++; rd_cyc = cyc; end
      if (web !== 4'h0) begin web_cnt++; web_seen = web; end
      if (rd === 1'b1 && web !== 4'h0) both_bad++;
      if (a !== addr || d !== wdata) hold_bad++;
      if (req_ready !== 1'b0) rdy_bad++;
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        n_vec++;
        if (cyc != exp_lat) begin
          n_bad++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat);
        end
        n_vec++;
        if (resp_rdata !== exp_data || resp_err !== exp_err) begin
          n_bad++; $display("FAIL %s resp: rdata=%h err=%b expected %h/%b", tag, resp_rdata, resp_err, exp_data, exp_err);
        end
      end else begin
        if (tied) ready = 1'b1;
        else if (cyc == 1) ready = 1'($urandom);
        else ready = (cyc == 2 + nwait);
        spo = (tied || cyc == 2 + nwait) ? dev_data : $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      n_vec++; n_bad++; $display("FAIL %s no resp_valid within 64 cycles", tag);
    end
    n_vec++;
    if (rd_cnt != (is_rd ? 1 : 0) || (is_rd && rd_cyc != 1)) begin
      n_bad++; $display("FAIL %s rd pulse: count %0d at cycle %0d expected %0d at 1", tag, rd_cnt, rd_cyc, is_rd);
    end
    n_vec++;
    if (web_cnt != (is_rd ? 0 : 1) || web_seen !== (is_rd ? 4'h0 : wstrb)) begin
      n_bad++; $display("FAIL %s web pulse: count %0d value %h expected %0d of %h", tag, web_cnt, web_seen, !is_rd, wstrb);
    end
    n_vec++;
    if (both_bad != 0 || hold_bad != 0 || rdy_bad != 0) begin
      n_bad++; $display("FAIL %s bus hold: overlap %0d a/d changes %0d req_ready highs %0d expected 0/0/0", tag, both_bad, hold_bad, rdy_bad);
    end
    ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_data || resp_err !== exp_err) begin
      n_bad++; $display("FAIL %s after resp: valid=%b rdy=%b rdata=%h err=%b expected 0/1/%h/%b", tag, resp_valid, req_ready, resp_rdata, resp_err, exp_data, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; ready = 1'b0; spo = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, rd, web, a, d, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 96'h0}) begin
      n_bad++; $display("FAIL reset values: rdy=%b rv=%b err=%b rd=%b web=%h a=%h d=%h rdata=%h expected 1/0/0/0/0/0/0/0",
                        req_ready, resp_valid, resp_err, rd, web, a, d, resp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    run_txn("zero_wait_read", 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b1);
  endtask

  task automatic test_write_wait();
    run_txn("write_wait5", 32'h0000_0200, 32'hAABB_CCDD, 4'b0011, 5, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout_read", 32'h9000_0000, 32'h0, 4'h0, 1000, 32'h0BAD_0BAD, 1'b0);
    run_txn("timeout_write", 32'h9000_0004, 32'h1111_2222, 4'hF, 1000, 32'h0, 1'b0);
    run_txn("after_timeout", 32'h0000_0300, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_timeout_boundary();
    run_txn("boundary_read", 32'h0000_0400, 32'h0, 4'h0, TO - 1, 32'h600D_DA7A, 1'b0);
  endtask

  // Two requests offered with req_valid held high against a zero-wait device.
  task automatic test_back_to_back();
    logic [31:0] a1, a2, dat;
    bit          e_rdy, e_rv, e_rd;
    logic [3:0]  e_web;
    a1 = 32'h0000_1000; a2 = 32'h0000_2000; dat = 32'h7777_8888;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = (i < 5); req_addr = (i < 4) ? a1 : a2; req_wdata = dat;
      req_wstrb = (i < 4) ? 4'h0 : 4'hF; ready = 1'b1; spo = 32'h3C3C_A5A5;
      e_rdy = (i % 4 == 0) || (i >= 8);
      e_rv  = (i < 8) && (i % 4 == 3);
      e_rd  = (i == 1);
      e_web = (i == 5) ? 4'hF : 4'h0;
      n_vec++;
      if ({req_ready, resp_valid, rd, web} !== {e_rdy, e_rv, e_rd, e_web}) begin
        n_bad++; $display("FAIL b2b cycle %0d: rdy/rv/rd/web=%b/%b/%b/%h expected %b/%b/%b/%h",
                          i, req_ready, resp_valid, rd, web, e_rdy, e_rv, e_rd, e_web);
      end
      if (i == 3 || i == 7) begin
        n_vec++;
        if (resp_rdata !== ((i == 3) ? 32'h3C3C_A5A5 : 32'h0) || resp_err !== 1'b0) begin
          n_bad++; $display("FAIL b2b resp at %0d: rdata=%h err=%b", i, resp_rdata, resp_err);
        end
      end
      if (i == 5) begin
        n_vec++;
        if (a !== a2 || d !== dat) begin
          n_bad++; $display("FAIL b2b second addr: a=%h d=%h expected %h/%h", a, d, a2, dat);
        end
      end
    end
    req_valid = 1'b0; ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_5000; req_wdata = 32'h0; req_wstrb = 4'h0; ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, rd, web, a, d, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 96'h0}) begin
      n_bad++; $display("FAIL mid reset values: rdy=%b rv=%b err=%b rd=%b web=%h a=%h d=%h rdata=%h expected 1/0/0/0/0/0/0/0",
                        req_ready, resp_valid, resp_err, rd, web, a, d, resp_rdata);
    end
    rst_n = 1'b1; ready = 1'b1; rv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid === 1'b1) rv_seen++;
    end
    n_vec++;
    if (rv_seen != 0) begin
      n_bad++; $display("FAIL mid reset stray resp_valid: %0d pulses expected 0", rv_seen);
    end
    ready = 1'b0;
    run_txn("post_reset_read", 32'h0000_5004, 32'h0, 4'h0, 1, 32'hFEED_BEEF, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] ws;
    for (int k = 0; k < 16; k++) begin
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn($sformatf("rand%0d", k), $urandom, $urandom, ws, $urandom_range(0, 11), $urandom, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
